// File: rtl/cdb_pkg.sv
// Shared CDB definitions: bus widths, the broadcast packet and the slot-reservation entry.
// Also used by the register status table and the reservation stations.
package cdb_pkg;
   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdb_pkt_t;

   typedef enum logic {
      OWN_MUL = 1'b0,
      OWN_DIV = 1'b1
   } slot_owner_e;

   typedef struct packed {
      logic        reserved;
      slot_owner_e owner;
   } slot_t;
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr_q.
// The pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             found;
   int               idx;

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d    = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: fixed-latency units reserve future slots at issue time,
// variable-latency units share the remaining cycles round-robin. CDB is registered.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      rsv_mul_req,
   output logic                      rsv_mul_grant,
   input  logic                      rsv_div_req,
   output logic                      rsv_div_grant,
   input  logic                      mul_valid,
   input  logic [TAG_W-1:0]          mul_tag,
   input  logic [DATA_W-1:0]         mul_data,
   input  logic                      div_valid,
   input  logic [TAG_W-1:0]          div_tag,
   input  logic [DATA_W-1:0]         div_data,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic                      rsv_error
);
   // s_q[k] describes the bus slot k cycles from now.
   slot_t [DIV_LAT:0] s_q, s_d;
   cdb_pkt_t          cdb_q, cdb_d;
   logic              err_q, err_d;
   logic              slot_mul, slot_div;
   logic [NUM_REQ-1:0] gnt;

   assign rsv_div_grant = rsv_div_req & ~s_q[DIV_LAT].reserved;
   assign rsv_mul_grant = rsv_mul_req & ~s_q[MUL_LAT].reserved;

   always_comb begin
      for (int k = 0; k < DIV_LAT; k++) s_d[k] = s_q[k+1];
      s_d[DIV_LAT] = '0;
      if (rsv_div_grant) s_d[DIV_LAT-1] = '{reserved: 1'b1, owner: OWN_DIV};
      if (rsv_mul_grant) s_d[MUL_LAT-1] = '{reserved: 1'b1, owner: OWN_MUL};
   end

   assign slot_mul = s_q[0].reserved && (s_q[0].owner == OWN_MUL);
   assign slot_div = s_q[0].reserved && (s_q[0].owner == OWN_DIV);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (req_valid),
      .en    (~s_q[0].reserved),
      .gnt   (gnt)
   );

   assign req_ready = gnt;

   always_comb begin
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
      err_d       = err_q;
      if (slot_mul) begin
         if (mul_valid) cdb_d = '{valid: 1'b1, tag: mul_tag, data: mul_data};
         else           err_d = 1'b1;
      end else if (slot_div) begin
         if (div_valid) cdb_d = '{valid: 1'b1, tag: div_tag, data: div_data};
         else           err_d = 1'b1;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i])
               cdb_d = '{valid: 1'b1, tag: req_tag[i*TAG_W +: TAG_W],
                         data: req_data[i*DATA_W +: DATA_W]};
         end
      end
      // A fixed-latency result outside its own slot is dropped and flagged.
      if (mul_valid && !slot_mul) err_d = 1'b1;
      if (div_valid && !slot_div) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q   <= '0;
         cdb_q <= '0;
         err_q <= 1'b0;
      end else begin
         s_q   <= s_d;
         cdb_q <= cdb_d;
         err_q <= err_d;
      end
   end

   assign cdb_valid = cdb_q.valid;
   assign cdb_tag   = cdb_q.tag;
   assign cdb_data  = cdb_q.data;
   assign rsv_error = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: reservations are tracked by absolute cycle number,
// expected CDB contents are queued per cycle and popped by an independent monitor.
module tb_cdb_arbiter;
   import cdb_pkg::*;
   localparam int N  = 4;
   localparam int ML = 4;
   localparam int DL = 7;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N-1:0]         req_valid, req_ready;
   logic [N*TAG_W-1:0]   req_tag;
   logic [N*DATA_W-1:0]  req_data;
   logic                 rsv_mul_req, rsv_mul_grant, rsv_div_req, rsv_div_grant;
   logic                 mul_valid, div_valid;
   logic [TAG_W-1:0]     mul_tag, div_tag, cdb_tag;
   logic [DATA_W-1:0]    mul_data, div_data, cdb_data;
   logic                 cdb_valid, rsv_error;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(N), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
      .rsv_mul_req(rsv_mul_req), .rsv_mul_grant(rsv_mul_grant),
      .rsv_div_req(rsv_div_req), .rsv_div_grant(rsv_div_grant),
      .mul_valid(mul_valid), .mul_tag(mul_tag), .mul_data(mul_data),
      .div_valid(div_valid), .div_tag(div_tag), .div_data(div_data),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rsv_error(rsv_error)
   );

   typedef struct {
      logic              v;
      logic [TAG_W-1:0]  t;
      logic [DATA_W-1:0] d;
      logic              e;
   } exp_t;
   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   // Reference state: absolute cycle -> owner (0 mul, 1 div) plus the result that unit will return.
   int                cyc, ptr;
   logic              m_err;
   logic [TAG_W-1:0]  m_tag;
   logic [DATA_W-1:0] m_data;
   logic              pend[N];
   logic [TAG_W-1:0]  ptag[N];
   logic [DATA_W-1:0] pdata[N];
   int                rsv_own[int];
   logic [TAG_W-1:0]  rsv_tag[int];
   logic [DATA_W-1:0] rsv_dat[int];
   logic              want_mul, want_div, inj_mul, skip_owner;
   logic [TAG_W-1:0]  nxt_mtag, nxt_dtag;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle();
      want_mul = 1'b0; want_div = 1'b0; inj_mul = 1'b0; skip_owner = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      req_valid = '0; req_tag = '0; req_data = '0;
      rsv_mul_req = 1'b0; rsv_div_req = 1'b0;
      mul_valid = 1'b0; mul_tag = '0; mul_data = '0;
      div_valid = 1'b0; div_tag = '0; div_data = '0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      rsv_own.delete(); rsv_tag.delete(); rsv_dat.delete();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      ptr = 0; m_err = 1'b0; m_tag = '0; m_data = '0;
      chk("reset_cdb_valid", cdb_valid, 0);
      chk("reset_cdb_tag",   cdb_tag,   0);
      chk("reset_cdb_data",  cdb_data,  0);
      chk("reset_rsv_error", rsv_error, 0);
   endtask

   task automatic drive_cycle();
      int           w, own;
      logic         s0, mg, dg;
      logic [N-1:0] er;
      exp_t         e;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = pend[i];
         req_tag[i*TAG_W +: TAG_W]    = ptag[i];
         req_data[i*DATA_W +: DATA_W] = pdata[i];
      end
      s0  = rsv_own.exists(cyc);
      own = s0 ? rsv_own[cyc] : -1;
      mul_valid = 1'b0; mul_tag = '0; mul_data = '0;
      div_valid = 1'b0; div_tag = '0; div_data = '0;
      if (s0 && !skip_owner) begin
         if (own == 0) begin mul_valid = 1'b1; mul_tag = rsv_tag[cyc]; mul_data = rsv_dat[cyc]; end
         else          begin div_valid = 1'b1; div_tag = rsv_tag[cyc]; div_data = rsv_dat[cyc]; end
      end
      if (inj_mul) begin mul_valid = 1'b1; mul_tag = 6'h2A; mul_data = 32'hBAD0BAD0; end
      rsv_mul_req = want_mul;
      rsv_div_req = want_div;
      #1;
      w  = -1;
      er = '0;
      if (!s0)
         for (int k = 0; k < N; k++)
            if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      if (w >= 0) er[w] = 1'b1;
      mg = want_mul && !rsv_own.exists(cyc + ML);
      dg = want_div && !rsv_own.exists(cyc + DL);
      chk("req_ready", req_ready, er);
      chk("rsv_mul_grant", rsv_mul_grant, mg);
      chk("rsv_div_grant", rsv_div_grant, dg);
      e.v = 1'b0;
      if (s0) begin
         if (own == 0 && mul_valid)      begin e.v = 1'b1; m_tag = mul_tag; m_data = mul_data; end
         else if (own == 1 && div_valid) begin e.v = 1'b1; m_tag = div_tag; m_data = div_data; end
         else m_err = 1'b1;
      end else if (w >= 0) begin
         e.v = 1'b1; m_tag = ptag[w]; m_data = pdata[w];
         pend[w] = 1'b0;
         ptr = (w + 1) % N;
      end
      if (mul_valid && !(s0 && own == 0)) m_err = 1'b1;
      if (div_valid && !(s0 && own == 1)) m_err = 1'b1;
      e.t = m_tag; e.d = m_data; e.e = m_err;
      exp_q.push_back(e);
      if (mg) begin rsv_own[cyc+ML] = 0; rsv_tag[cyc+ML] = nxt_mtag; rsv_dat[cyc+ML] = $urandom; end
      if (dg) begin rsv_own[cyc+DL] = 1; rsv_tag[cyc+DL] = nxt_dtag; rsv_dat[cyc+DL] = $urandom; end
      if (s0) begin rsv_own.delete(cyc); rsv_tag.delete(cyc); rsv_dat.delete(cyc); end
      @(negedge clk);
      cyc++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cdb_valid", cdb_valid, e.v);
            if (e.v) begin
               chk("cdb_tag",  cdb_tag,  e.t);
               chk("cdb_data", cdb_data, e.d);
            end else begin
               chk("cdb_tag_hold",  cdb_tag,  e.t);
               chk("cdb_data_hold", cdb_data, e.d);
            end
            chk("rsv_error", rsv_error, e.e);
         end
      end
   end

   initial begin
      cyc = 0; idle(); nxt_mtag = '0; nxt_dtag = '0;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; ptag[i] = '0; pdata[i] = '0; end
      do_reset(2);

      // single request
      pend[0] = 1'b1; ptag[0] = 6'd5; pdata[0] = 32'hDEADBEEF;
      repeat (3) drive_cycle();

      // fairness: all four held high, refilled right after each grant
      do_reset(1);
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i]) begin pend[i] = 1'b1; ptag[i] = 6'(i + 1); pdata[i] = $urandom; end
         drive_cycle();
      end
      for (int i = 0; i < N; i++) pend[i] = 1'b0;

      // reserved multiplier slot pre-empts requester 0
      do_reset(1);
      nxt_mtag = 6'd9; want_mul = 1'b1;
      drive_cycle();
      idle();
      repeat (3) drive_cycle();
      pend[0] = 1'b1; ptag[0] = 6'd3; pdata[0] = 32'h00C0FFEE;
      repeat (4) drive_cycle();

      // slot conflict between divider and a later multiplier
      do_reset(1);
      nxt_dtag = 6'd11; want_div = 1'b1;
      drive_cycle();
      idle();
      repeat (2) drive_cycle();
      nxt_mtag = 6'd12; want_mul = 1'b1;
      repeat (2) drive_cycle();
      idle();
      repeat (7) drive_cycle();

      // randomized traffic, all legal
      do_reset(1);
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1; ptag[i] = 6'($urandom); pdata[i] = $urandom;
            end
         want_mul = ($urandom_range(2, 0) == 0);
         want_div = ($urandom_range(3, 0) == 0);
         nxt_mtag = 6'($urandom); nxt_dtag = 6'($urandom);
         drive_cycle();
      end
      idle();
      repeat (12) drive_cycle();

      // owner fails to deliver in its reserved slot
      want_mul = 1'b1; nxt_mtag = 6'd20;
      drive_cycle();
      idle();
      repeat (3) drive_cycle();
      skip_owner = 1'b1;
      drive_cycle();
      skip_owner = 1'b0;
      repeat (3) drive_cycle();

      // unreserved multiplier result: dropped, sticky error
      do_reset(1);
      inj_mul = 1'b1;
      drive_cycle();
      inj_mul = 1'b0;
      pend[2] = 1'b1; ptag[2] = 6'd7; pdata[2] = 32'h12345678;
      repeat (5) drive_cycle();

      // reset with reservations in flight
      do_reset(1);
      want_mul = 1'b1; want_div = 1'b1;
      drive_cycle();
      idle();
      drive_cycle();
      do_reset(2);
      for (int i = 0; i < N; i++) begin pend[i] = 1'b1; ptag[i] = 6'(40 + i); pdata[i] = $urandom; end
      want_mul = 1'b1; want_div = 1'b1;
      drive_cycle();
      idle();
      repeat (12) drive_cycle();

      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between execution units in the Tomasulo core.
- Variable-latency units (integer ALU, load/store, ...) request the bus with a valid/ready handshake and are served round-robin.
- Fixed-latency units (multiplier, divider) reserve a CDB slot at issue time; a reserved slot pre-empts all variable-latency requesters in that cycle.
- Drives the registered cdb_valid/cdb_tag/cdb_data consumed by the register status table, the reservation stations and the register file.

Parameters:
- NUM_REQ, 4, number of variable-latency requesters.
- TAG_W, 6, width of the physical/ROB tag.
- DATA_W, 32, width of the result data.
- MUL_LAT, 4, cycles from multiplier issue to mul_valid; must satisfy 1 <= MUL_LAT < DIV_LAT.
- DIV_LAT, 7, cycles from divider issue to div_valid.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester result valid
- req_tag  in  NUM_REQ*TAG_W  per-requester tag, requester i in slice [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  per-requester data, requester i in slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rsv_mul_req  in  1  multiplier issuing this cycle, needs the slot at now+MUL_LAT
- rsv_mul_grant  out  1  combinational; multiplier may issue
- rsv_div_req  in  1  divider issuing this cycle, needs the slot at now+DIV_LAT
- rsv_div_grant  out  1  combinational; divider may issue
- mul_valid, mul_tag, mul_data  in  1, TAG_W, DATA_W  multiplier result
- div_valid, div_tag, div_data  in  1, TAG_W, DATA_W  divider result
- cdb_valid  out  1  registered CDB valid
- cdb_tag  out  TAG_W  registered CDB tag
- cdb_data  out  DATA_W  registered CDB data
- rsv_error  out  1  sticky protocol-violation flag

Behaviour:
Reset:
- Clock is clk; reset is synchronous and active-high.
- On reset: reservation vector cleared, round-robin pointer = 0, cdb_valid = 0, cdb_tag = 0, cdb_data = 0, rsv_error = 0.
- Reset mid-operation discards all reservations. The execution units are reset in the same cycle.

Slot vector:
- s[0..DIV_LAT], each entry holding a reserved bit plus an owner bit (0 = mul, 1 = div). s[k] is the slot for the cycle now+k.
- Every clock edge: s_next[k] = s[k+1]; the top entry is cleared.
- rsv_div_grant = rsv_div_req & !s[DIV_LAT].reserved. When granted, s_next[DIV_LAT-1] is set with owner = div.
- rsv_mul_grant = rsv_mul_req & !s[MUL_LAT].reserved. When granted, s_next[MUL_LAT-1] is set with owner = mul.
- Both grants may be given in the same cycle, because they target different slots.

Per-cycle selection:
- If s[0].reserved: select the owner's result. All req_ready = 0.
  - If the owner's valid = 0, set rsv_error and drive no CDB transfer in the following cycle.
- Otherwise: round-robin among req_valid, starting the search at the pointer.
  - The winner's req_ready = 1; a transfer occurs when valid & ready.
  - The pointer becomes winner+1 (mod NUM_REQ) only on a grant; with no requests it holds.
- A requester keeps req_valid and payload stable until it sees ready. req_ready never depends on the requester's own ready.

Errors:
- mul_valid or div_valid asserted when s[0] is not reserved for that unit sets rsv_error. That result is dropped.
- rsv_error stays set until reset.

CDB output:
- Registered; latency is 1 cycle from selection to cdb_valid.
- With no selection, cdb_valid = 0 and cdb_tag/cdb_data hold their previous values.

Decomposition:
- Shared package: TAG_W, DATA_W, and a cdb_pkt typedef {valid, tag, data}. The register status table and reservation stations reuse it.
- One sub-module, rr_arbiter: parameterised NUM_REQ round-robin with request vector, enable, one-hot grant and pointer register.

Test Plan:
1. Single request: req_valid[0]=1, tag 5, data 0xDEADBEEF at cycle t -> req_ready[0]=1 at t; cdb_valid=1, tag 5, data 0xDEADBEEF at t+1; cdb_valid=0 at t+2.
2. Round-robin fairness: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; exactly one req_ready bit high per cycle.
3. Reserved slot pre-empts: rsv_mul_req at t, mul_valid with tag 9 at t+4, req_valid[0] held -> rsv_mul_grant=1 at t; req_ready=0 at t+4; cdb_tag=9 at t+5; requester 0 granted at t+5, its tag on the CDB at t+6.
4. Slot conflict: rsv_div_req at t (slot t+7), rsv_mul_req at t+3 (slot t+7) -> rsv_mul_grant=0 at t+3; rsv_mul_req at t+4 -> grant=1; div tag on the CDB at t+8, mul tag at t+9.
5. Protocol violation: mul_valid=1 with no reservation -> rsv_error=1 next cycle, no CDB transfer of that tag, rsv_error stays high until reset.
6. Reset mid-operation: reset for 2 cycles with mul and div reservations pending -> cdb_valid=0, rsv_error=0, both grants available immediately after reset, pointer restarts at requester 0.
